// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: single-word req/ack memory port between the stack controller and data memory
interface stack_ctrl_if #(parameter int WIDTH = 32);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: SP register plus push/pop sequencing onto a req/ack memory port.
// Optional STACK_DEPTH_EN adds registered depth and high_water outputs.
module stack_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] SP_RESET   = 32'h10010100,
    parameter logic [WIDTH-1:0] SP_LIMIT   = 32'h10010000,
    parameter int               WORD_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp_wr_en,
    input  logic [WIDTH-1:0] sp_wr_data,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    stack_ctrl_if.master     mem,
    output logic [WIDTH-1:0] sp,
    output logic             overflow,
    output logic             underflow,
`ifdef STACK_DEPTH_EN
    output logic [WIDTH-1:0] depth,
    output logic [WIDTH-1:0] high_water,
`endif
    input  logic             clr_flags
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;
    state_t state;

    logic [WIDTH-1:0] push_addr;
    logic [WIDTH-1:0] sp_nxt;

    assign push_addr = sp - STEP;

    always_comb begin
        sp_nxt = (state == IDLE && sp_wr_en)     ? sp_wr_data :
                 (state == PUSH && mem.mem_ack)  ? sp - STEP  :
                 (state == POP  && mem.mem_ack)  ? sp + STEP  : sp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sp            <= SP_RESET;
            ready         <= 1'b1;
            pop_data      <= '0;
            pop_valid     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            pop_valid <= 1'b0;
            if (clr_flags) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sp_wr_en) begin
                    end else if (push_req) begin
                        if (push_addr < SP_LIMIT) begin
                            overflow <= 1'b1;
                        end else begin
                            mem.mem_addr  <= push_addr;
                            mem.mem_wdata <= push_data;
                            mem.mem_we    <= 1'b1;
                            mem.mem_req   <= 1'b1;
                            ready         <= 1'b0;
                            state         <= PUSH;
                        end
                    end else if (pop_req) begin
                        if (sp >= SP_RESET) begin
                            underflow <= 1'b1;
                        end else begin
                            mem.mem_addr <= sp;
                            mem.mem_we   <= 1'b0;
                            mem.mem_req  <= 1'b1;
                            ready        <= 1'b0;
                            state        <= POP;
                        end
                    end
                end
                PUSH: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        ready       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                POP: begin
                    if (mem.mem_ack) begin
                        pop_data    <= mem.mem_rdata;
                        pop_valid   <= 1'b1;
                        mem.mem_req <= 1'b0;
                        ready       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STACK_DEPTH_EN
    // An SP written above the empty top counts as an empty stack.
    logic [WIDTH-1:0] depth_nxt;
    assign depth_nxt = (sp_nxt > SP_RESET) ? '0 : (SP_RESET - sp_nxt) / STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth      <= '0;
            high_water <= '0;
        end else begin
            depth <= depth_nxt;
            if (depth_nxt > high_water) high_water <= depth_nxt;
        end
    end
`endif
endmodule
